// File: rtl/trap_irq_pkg.sv
// Package trap_irq_pkg
//   Shared definitions for the interrupt front-end of the CSR/trap unit:
//   privilege codes, standard interrupt indices, the handshake FSM state
//   encoding and the RISC-V interrupt priority picker.
package trap_irq_pkg;

    localparam logic [1:0] PRIV_U = 2'd0;
    localparam logic [1:0] PRIV_S = 2'd1;
    localparam logic [1:0] PRIV_M = 2'd3;

    localparam logic [4:0] IRQ_SSI = 5'd1;
    localparam logic [4:0] IRQ_MSI = 5'd3;
    localparam logic [4:0] IRQ_STI = 5'd5;
    localparam logic [4:0] IRQ_MTI = 5'd7;
    localparam logic [4:0] IRQ_SEI = 5'd9;
    localparam logic [4:0] IRQ_MEI = 5'd11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } irq_fsm_e;

    typedef struct packed {
        logic       valid;
        logic [4:0] idx;
    } irq_pick_t;

    // Priority 11 > 3 > 7 > 9 > 1 > 5 > highest remaining index.
    // The generic scan runs first and the named lines override it, applied
    // lowest priority first so the highest named line present ends up last.
    function automatic irq_pick_t prio_pick(input logic [31:0] vec);
        irq_pick_t r;
        r.valid = |vec;
        r.idx   = '0;
        for (int i = 0; i < 32; i++) begin
            if (vec[i]) begin
                r.idx = 5'(i);
            end
        end
        if (vec[IRQ_STI]) r.idx = IRQ_STI;
        if (vec[IRQ_SSI]) r.idx = IRQ_SSI;
        if (vec[IRQ_SEI]) r.idx = IRQ_SEI;
        if (vec[IRQ_MTI]) r.idx = IRQ_MTI;
        if (vec[IRQ_MSI]) r.idx = IRQ_MSI;
        if (vec[IRQ_MEI]) r.idx = IRQ_MEI;
        return r;
    endfunction

endpackage

// File: rtl/irq_sync.sv
// Module irq_sync
//   STAGES-deep flop chain per bit bringing asynchronous interrupt lines into
//   the clk domain. All stages clear on reset.
// Ports
//   clk     in  1      clock
//   resetn  in  1      synchronous, active-low reset
//   d_i     in  WIDTH  asynchronous inputs
//   q_o     out WIDTH  synchronised outputs (STAGES cycles of delay)
module irq_sync #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_d [STAGES];
    logic [WIDTH-1:0] stage_q [STAGES];

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        if (gi == 0) begin : g_first
            assign stage_d[gi] = d_i;
        end else begin : g_rest
            assign stage_d[gi] = stage_q[gi-1];
        end

        always_ff @(posedge clk) begin
            if (!resetn) begin
                stage_q[gi] <= '0;
            end else begin
                stage_q[gi] <= stage_d[gi];
            end
        end
    end

    assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/trap_irq_arbiter.sv
// Module trap_irq_arbiter
//   Interrupt front-end for the CSR/trap unit. Synchronises NUM_IRQ lines,
//   holds pending state, masks it with mie/mideleg/mstatus, picks a winner by
//   RISC-V priority and offers it to the control FSM over a req/ack handshake.
//   Build option: TRAP_IRQ_EDGE_EN -- when defined, lines set in EDGE_MASK
//   latch rising edges (sticky until ack or pend_clr); otherwise every line is
//   level-sensitive and EDGE_MASK/pend_clr/pend_clr_idx have no effect.
// Ports
//   clk, resetn           clock, synchronous active-low reset
//   irq_i [NUM_IRQ]       asynchronous interrupt lines
//   mie, mideleg          CSR enable / delegation masks
//   mstatus_mie/sie       global M / S enables
//   priv_mode [2]         current privilege (0 U, 1 S, 3 M)
//   pend_clr, pend_clr_idx  CSR clear of an edge pending bit
//   irq_req, irq_cause, irq_to_s  request, cause, target (1 = S) to control FSM
//   irq_ack               request accepted
//   mip_o [NUM_IRQ]       pending vector for mip/sip read-back
module trap_irq_arbiter
    import trap_irq_pkg::*;
#(
    parameter int                 NUM_IRQ     = 16,
    parameter int                 SYNC_STAGES = 2,
    parameter logic [NUM_IRQ-1:0] EDGE_MASK   = '0
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [NUM_IRQ-1:0] irq_i,
    input  logic [NUM_IRQ-1:0] mie,
    input  logic [NUM_IRQ-1:0] mideleg,
    input  logic               mstatus_mie,
    input  logic               mstatus_sie,
    input  logic [1:0]         priv_mode,
    input  logic               pend_clr,
    input  logic [4:0]         pend_clr_idx,
    output logic               irq_req,
    output logic [31:0]        irq_cause,
    output logic               irq_to_s,
    input  logic               irq_ack,
    output logic [NUM_IRQ-1:0] mip_o
);

    logic [NUM_IRQ-1:0] irq_sync_w;
    logic [NUM_IRQ-1:0] pend_d, pend_q;
    irq_fsm_e           state_d, state_q;
    logic [4:0]         idx_d, idx_q;
    logic               to_s_d, to_s_q;

    irq_sync #(
        .WIDTH  (NUM_IRQ),
        .STAGES (SYNC_STAGES)
    ) u_irq_sync (
        .clk    (clk),
        .resetn (resetn),
        .d_i    (irq_sync_w_src()),
        .q_o    (irq_sync_w)
    );

    function automatic logic [NUM_IRQ-1:0] irq_sync_w_src();
        return irq_i;
    endfunction

    // ---------------- pending state ----------------
`ifdef TRAP_IRQ_EDGE_EN
    logic [NUM_IRQ-1:0] sync_prev_d, sync_prev_q;
    logic               ack_take;

    assign sync_prev_d = irq_sync_w;
    assign ack_take    = (state_q == ST_REQ) && irq_ack;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync_prev_q <= '0;
        end else begin
            sync_prev_q <= sync_prev_d;
        end
    end

    for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_pend
        if (EDGE_MASK[gi]) begin : g_edge
            logic rise, clr;
            // Indices >= NUM_IRQ never match any gi, so out-of-range clears drop out.
            assign rise = irq_sync_w[gi] & ~sync_prev_q[gi];
            assign clr  = (ack_take && (idx_q == 5'(gi)))
                        | (pend_clr && (pend_clr_idx == 5'(gi)));
            // Set has precedence over a simultaneous clear.
            assign pend_d[gi] = rise | (pend_q[gi] & ~clr);
        end else begin : g_level
            assign pend_d[gi] = irq_sync_w[gi];
        end
    end
`else
    logic unused_edge_cfg;
    assign unused_edge_cfg = ^{pend_clr, pend_clr_idx, EDGE_MASK};
    assign pend_d = irq_sync_w;
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign mip_o = pend_q;

    // ---------------- eligibility and priority ----------------
    logic               m_ok, s_ok;
    logic [NUM_IRQ-1:0] elig, elig_m, elig_s;
    logic [31:0]        elig_ext;
    irq_pick_t          win_m, win_s;

    // Non-delegated lines trap to M: taken below M always, in M only with MIE.
    // Delegated lines trap to S: taken in U always, in S with SIE, never in M.
    assign m_ok = (priv_mode != PRIV_M) | mstatus_mie;
    assign s_ok = (priv_mode == PRIV_U) | ((priv_mode == PRIV_S) & mstatus_sie);

    assign elig   = pend_q & mie & ((~mideleg & {NUM_IRQ{m_ok}}) | (mideleg & {NUM_IRQ{s_ok}}));
    assign elig_m = elig & ~mideleg;
    assign elig_s = elig & mideleg;

    assign elig_ext = 32'(elig);
    assign win_m    = prio_pick(32'(elig_m));
    assign win_s    = prio_pick(32'(elig_s));

    // ---------------- handshake FSM ----------------
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        to_s_d  = to_s_q;
        unique case (state_q)
            ST_IDLE: begin
                if (win_m.valid) begin
                    idx_d   = win_m.idx;
                    to_s_d  = 1'b0;
                    state_d = ST_REQ;
                end else if (win_s.valid) begin
                    idx_d   = win_s.idx;
                    to_s_d  = 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                // The registered winner is held; only ack or loss of
                // eligibility ends the request (ack takes precedence).
                if (irq_ack || !elig_ext[idx_q]) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            to_s_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            to_s_q  <= to_s_d;
        end
    end

    assign irq_req   = (state_q == ST_REQ);
    assign irq_cause = irq_req ? {1'b1, 26'b0, idx_q} : 32'h0;
    assign irq_to_s  = irq_req & to_s_q;

endmodule

// File: tb/tb_trap_irq_arbiter.sv
module tb_trap_irq_arbiter;
    import trap_irq_pkg::*;

    localparam int NUM_IRQ     = 16;
    localparam int SYNC_STAGES = 2;
    localparam int LAT         = SYNC_STAGES + 2;
    localparam int NV          = 14;

    logic               clk = 1'b0;
    logic               resetn;
    logic [NUM_IRQ-1:0] irq_i, mie, mideleg, mip_o;
    logic               mstatus_mie, mstatus_sie, pend_clr, irq_req, irq_to_s, irq_ack;
    logic [1:0]         priv_mode;
    logic [4:0]         pend_clr_idx;
    logic [31:0]        irq_cause;

    always #5 clk = ~clk;

    trap_irq_arbiter #(
        .NUM_IRQ     (NUM_IRQ),
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE_MASK   (16'h0008)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .irq_i        (irq_i),
        .mie          (mie),
        .mideleg      (mideleg),
        .mstatus_mie  (mstatus_mie),
        .mstatus_sie  (mstatus_sie),
        .priv_mode    (priv_mode),
        .pend_clr     (pend_clr),
        .pend_clr_idx (pend_clr_idx),
        .irq_req      (irq_req),
        .irq_cause    (irq_cause),
        .irq_to_s     (irq_to_s),
        .irq_ack      (irq_ack),
        .mip_o        (mip_o)
    );

    typedef struct {
        logic [15:0] irq, en, deleg;
        logic        gm, gs;
        logic [1:0]  priv;
        logic        exp_req;
        logic [31:0] exp_cause;
        logic        exp_to_s;
    } vec_t;

    typedef struct {
        int          id;
        logic        req;
        logic [31:0] cause;
        logic        to_s;
        logic [15:0] mip;
    } exp_t;

    vec_t vecs [NV];
    exp_t sb_q [$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic do_reset();
        resetn = 1'b0; irq_i = '0; mie = '0; mideleg = '0;
        mstatus_mie = 1'b0; mstatus_sie = 1'b0; priv_mode = PRIV_M;
        pend_clr = 1'b0; pend_clr_idx = '0; irq_ack = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
    endtask

    // Cycles from now until irq_req is seen; 0 if the budget expires.
    task automatic wait_req(output int cyc);
        cyc = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (irq_req) begin
                cyc = c;
                break;
            end
        end
    endtask

    initial begin
        int   cyc, seen;
        exp_t e;

        //          irq       mie       mideleg   gm    gs    priv    req   cause          to_s
        vecs[0]  = '{16'h0080, 16'h0080, 16'h0000, 1'b1, 1'b0, PRIV_M, 1'b1, 32'h8000_0007, 1'b0};
        vecs[1]  = '{16'h0880, 16'h0880, 16'h0000, 1'b1, 1'b0, PRIV_M, 1'b1, 32'h8000_000B, 1'b0};
        vecs[2]  = '{16'h0200, 16'h0200, 16'h0200, 1'b0, 1'b1, PRIV_S, 1'b1, 32'h8000_0009, 1'b1};
        vecs[3]  = '{16'h0200, 16'h0200, 16'h0200, 1'b1, 1'b1, PRIV_M, 1'b0, 32'h0,          1'b0};
        vecs[4]  = '{16'h0080, 16'h0080, 16'h0000, 1'b0, 1'b0, PRIV_M, 1'b0, 32'h0,          1'b0};
        vecs[5]  = '{16'h0080, 16'h0080, 16'h0000, 1'b0, 1'b0, PRIV_S, 1'b1, 32'h8000_0007, 1'b0};
        vecs[6]  = '{16'h0202, 16'h0202, 16'h0202, 1'b0, 1'b0, PRIV_U, 1'b1, 32'h8000_0009, 1'b1};
        vecs[7]  = '{16'h0808, 16'h0808, 16'h0800, 1'b0, 1'b1, PRIV_S, 1'b1, 32'h8000_0003, 1'b0};
        vecs[8]  = '{16'hC001, 16'hFFFF, 16'h0000, 1'b1, 1'b0, PRIV_M, 1'b1, 32'h8000_000F, 1'b0};
        vecs[9]  = '{16'h8020, 16'hFFFF, 16'h0000, 1'b1, 1'b0, PRIV_M, 1'b1, 32'h8000_0005, 1'b0};
        vecs[10] = '{16'h0022, 16'hFFFF, 16'h0000, 1'b1, 1'b0, PRIV_M, 1'b1, 32'h8000_0001, 1'b0};
        vecs[11] = '{16'h0288, 16'hFFFF, 16'h0000, 1'b1, 1'b0, PRIV_M, 1'b1, 32'h8000_0003, 1'b0};
        vecs[12] = '{16'h0080, 16'h0000, 16'h0000, 1'b1, 1'b0, PRIV_M, 1'b0, 32'h0,          1'b0};
        vecs[13] = '{16'h0200, 16'h0200, 16'h0200, 1'b1, 1'b0, PRIV_S, 1'b0, 32'h0,          1'b0};

        // Reset state
        do_reset();
        resetn = 1'b0;
        @(negedge clk);
        check("reset_req",   32'(irq_req),  32'h0);
        check("reset_cause", irq_cause,     32'h0);
        check("reset_to_s",  32'(irq_to_s), 32'h0);
        check("reset_mip",   32'(mip_o),    32'h0);

        // Table-driven vectors with a scoreboard queue
        for (int v = 0; v < NV; v++) begin
            do_reset();
            irq_i = vecs[v].irq; mie = vecs[v].en; mideleg = vecs[v].deleg;
            mstatus_mie = vecs[v].gm; mstatus_sie = vecs[v].gs; priv_mode = vecs[v].priv;
            sb_q.push_back('{v, vecs[v].exp_req, vecs[v].exp_cause, vecs[v].exp_to_s, vecs[v].irq});

            e = sb_q.pop_front();
            if (e.req) begin
                wait_req(cyc);
                check($sformatf("v%0d_latency", e.id), 32'(cyc),      32'(LAT));
                check($sformatf("v%0d_cause",   e.id), irq_cause,     e.cause);
                check($sformatf("v%0d_to_s",    e.id), 32'(irq_to_s), 32'(e.to_s));
                check($sformatf("v%0d_mip",     e.id), 32'(mip_o),    32'(e.mip));
                irq_ack = 1'b1;
                @(negedge clk);
                irq_ack = 1'b0;
                check($sformatf("v%0d_ack_drop", e.id), 32'(irq_req), 32'h0);
            end else begin
                seen = 0;
                for (int c = 0; c < LAT + 4; c++) begin
                    @(negedge clk);
                    if (irq_req) seen++;
                end
                check($sformatf("v%0d_no_req", e.id), 32'(seen),  32'h0);
                check($sformatf("v%0d_mip",    e.id), 32'(mip_o), 32'(e.mip));
            end
        end

        // 11 and 7 together: 11 first, then 7 after one idle cycle; no re-arbitration in REQ
        do_reset();
        irq_i = 16'h0880; mie = 16'h0880; mstatus_mie = 1'b1; priv_mode = PRIV_M;
        wait_req(cyc);
        check("pair_first_cause", irq_cause, 32'h8000_000B);
        irq_ack = 1'b1; mie = 16'h0080;
        @(negedge clk);
        irq_ack = 1'b0;
        check("pair_idle_gap", 32'(irq_req), 32'h0);
        @(negedge clk);
        check("pair_second_req",   32'(irq_req), 32'h1);
        check("pair_second_cause", irq_cause,    32'h8000_0007);
        mie = 16'h0880;
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (!irq_req || irq_cause !== 32'h8000_0007) seen++;
        end
        check("pair_cause_stable", 32'(seen), 32'h0);
        irq_ack = 1'b1; mie = 16'h0;
        @(negedge clk);
        irq_ack = 1'b0;

        // Withdrawal without ack, then mask drop together with ack
        do_reset();
        irq_i = 16'h0080; mie = 16'h0080; mstatus_mie = 1'b1; priv_mode = PRIV_M;
        wait_req(cyc);
        mie = 16'h0;
        @(negedge clk);
        check("withdraw_req", 32'(irq_req), 32'h0);
        mie = 16'h0080;
        @(negedge clk);
        check("rearm_req", 32'(irq_req), 32'h1);
        irq_ack = 1'b1; mie = 16'h0;
        @(negedge clk);
        irq_ack = 1'b0;
        check("ack_with_drop_req", 32'(irq_req), 32'h0);

        // Reset in the middle of a handshake, line still high
        do_reset();
        irq_i = 16'h0200; mie = 16'h0200; mideleg = 16'h0200;
        mstatus_sie = 1'b1; priv_mode = PRIV_S;
        wait_req(cyc);
        resetn = 1'b0;
        @(negedge clk);
        check("midreset_req",   32'(irq_req),  32'h0);
        check("midreset_cause", irq_cause,     32'h0);
        check("midreset_to_s",  32'(irq_to_s), 32'h0);
        check("midreset_mip",   32'(mip_o),    32'h0);
        resetn = 1'b1;
        wait_req(cyc);
        check("rereq_latency", 32'(cyc),  32'(LAT));
        check("rereq_cause",   irq_cause, 32'h8000_0009);

`ifdef TRAP_IRQ_EDGE_EN
        // Edge line 3: pulse is sticky, cleared by pend_clr or by ack
        do_reset();
        mstatus_mie = 1'b1; priv_mode = PRIV_M;
        irq_i = 16'h0008;
        @(negedge clk);
        irq_i = 16'h0;
        repeat (5) @(negedge clk);
        check("edge_sticky", 32'(mip_o), 32'h0008);
        pend_clr = 1'b1; pend_clr_idx = 5'd20;
        @(negedge clk);
        pend_clr = 1'b0;
        check("edge_clr_out_of_range", 32'(mip_o), 32'h0008);
        pend_clr = 1'b1; pend_clr_idx = 5'd3;
        @(negedge clk);
        pend_clr = 1'b0;
        check("edge_pend_clr", 32'(mip_o), 32'h0);
        mie = 16'h0008;
        irq_i = 16'h0008;
        @(negedge clk);
        irq_i = 16'h0;
        wait_req(cyc);
        check("edge_req_cause", irq_cause, 32'h8000_0003);
        irq_ack = 1'b1;
        @(negedge clk);
        irq_ack = 1'b0;
        check("edge_ack_clear", 32'(mip_o), 32'h0);
        @(negedge clk);
        check("edge_no_rereq", 32'(irq_req), 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
